// File: rtl/chacha_pkg.sv
// Shared ChaCha definitions: widths, op selectors, FSM encoding, sigma constants
// and the quarter-round helper used by the round datapath.
package chacha_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned ROW_W     = 128;
    localparam int unsigned ROW_WORDS = ROW_W / WORD_W;
    localparam int unsigned ST_WORDS  = 4 * ROW_WORDS;

    localparam logic OP_COLUMN = 1'b0;
    localparam logic OP_DIAG   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ADD  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Row a occupies the most significant bits of the flattened state.
    typedef struct packed {
        logic [ROW_W-1:0] a;
        logic [ROW_W-1:0] b;
        logic [ROW_W-1:0] c;
        logic [ROW_W-1:0] d;
    } chacha_state_t;

    // "expand 32-byte k", row a of every ChaCha input state
    localparam logic [WORD_W-1:0] SIGMA0 = 32'h6170_7865;
    localparam logic [WORD_W-1:0] SIGMA1 = 32'h3320_646e;
    localparam logic [WORD_W-1:0] SIGMA2 = 32'h7962_2d32;
    localparam logic [WORD_W-1:0] SIGMA3 = 32'h6b20_6574;

    function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] x,
                                                input int unsigned     n);
        return (x << n) | (x >> (WORD_W - n));
    endfunction

    // Returns {a, b, c, d} after one ChaCha quarter round.
    function automatic logic [4*WORD_W-1:0] quarter_round(input logic [WORD_W-1:0] a_i,
                                                          input logic [WORD_W-1:0] b_i,
                                                          input logic [WORD_W-1:0] c_i,
                                                          input logic [WORD_W-1:0] d_i);
        logic [WORD_W-1:0] a;
        logic [WORD_W-1:0] b;
        logic [WORD_W-1:0] c;
        logic [WORD_W-1:0] d;
        a = a_i;
        b = b_i;
        c = c_i;
        d = d_i;
        a = a + b;  d = rotl(d ^ a, 16);
        c = c + d;  b = rotl(b ^ c, 12);
        a = a + b;  d = rotl(d ^ a, 8);
        c = c + d;  b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

endpackage

// File: rtl/chacha_block_ctrl_round.sv
// One ChaCha single round: four quarter rounds on columns or diagonals.
// Diagonal mode permutes the b/c/d operands in and scatters the results back.
module round
    import chacha_pkg::*;
(
    input  chacha_state_t i_state,
    input  logic          i_op_type,
    output chacha_state_t o_state
);

    logic [WORD_W-1:0] w_x  [ST_WORDS];
    logic [WORD_W-1:0] w_qa [ROW_WORDS];
    logic [WORD_W-1:0] w_qb [ROW_WORDS];
    logic [WORD_W-1:0] w_qc [ROW_WORDS];
    logic [WORD_W-1:0] w_qd [ROW_WORDS];
    logic [WORD_W-1:0] w_ya [ROW_WORDS];
    logic [WORD_W-1:0] w_yb [ROW_WORDS];
    logic [WORD_W-1:0] w_yc [ROW_WORDS];
    logic [WORD_W-1:0] w_yd [ROW_WORDS];

    for (genvar g = 0; g < int'(ROW_WORDS); g++) begin : g_lane
        // Diagonal operand sources for quarter round g
        localparam int unsigned SB = (g + 1) % 4;
        localparam int unsigned SC = (g + 2) % 4;
        localparam int unsigned SD = (g + 3) % 4;
        // Diagonal quarter round that produced output word g of rows b/c/d
        localparam int unsigned GB = (g + 3) % 4;
        localparam int unsigned GC = (g + 2) % 4;
        localparam int unsigned GD = (g + 1) % 4;

        logic [WORD_W-1:0] w_b;
        logic [WORD_W-1:0] w_c;
        logic [WORD_W-1:0] w_d;

        assign w_x[g]      = i_state.a[WORD_W*g +: WORD_W];
        assign w_x[4 + g]  = i_state.b[WORD_W*g +: WORD_W];
        assign w_x[8 + g]  = i_state.c[WORD_W*g +: WORD_W];
        assign w_x[12 + g] = i_state.d[WORD_W*g +: WORD_W];

        assign w_b = (i_op_type == OP_DIAG) ? w_x[4 + SB]  : w_x[4 + g];
        assign w_c = (i_op_type == OP_DIAG) ? w_x[8 + SC]  : w_x[8 + g];
        assign w_d = (i_op_type == OP_DIAG) ? w_x[12 + SD] : w_x[12 + g];

        assign {w_qa[g], w_qb[g], w_qc[g], w_qd[g]} = quarter_round(w_x[g], w_b, w_c, w_d);

        assign w_ya[g] = w_qa[g];
        assign w_yb[g] = (i_op_type == OP_COLUMN) ? w_qb[g] : w_qb[GB];
        assign w_yc[g] = (i_op_type == OP_COLUMN) ? w_qc[g] : w_qc[GC];
        assign w_yd[g] = (i_op_type == OP_COLUMN) ? w_qd[g] : w_qd[GD];
    end

    assign o_state = {w_ya[3], w_ya[2], w_ya[1], w_ya[0],
                      w_yb[3], w_yb[2], w_yb[1], w_yb[0],
                      w_yc[3], w_yc[2], w_yc[1], w_yc[0],
                      w_yd[3], w_yd[2], w_yd[1], w_yd[0]};

endmodule

// File: rtl/chacha_block_ctrl.sv
// ChaCha block sequencer: loads a state, runs ROUNDS single rounds through one
// shared round instance, adds the original state and holds the keystream block.
module chacha_block_ctrl
    import chacha_pkg::*;
#(
    parameter int unsigned ROUNDS = 20
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ROW_W-1:0] in_a,
    input  logic [ROW_W-1:0] in_b,
    input  logic [ROW_W-1:0] in_c,
    input  logic [ROW_W-1:0] in_d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ROW_W-1:0] out_a,
    output logic [ROW_W-1:0] out_b,
    output logic [ROW_W-1:0] out_c,
    output logic [ROW_W-1:0] out_d,
    output logic             busy
);

    localparam int unsigned      CNT_W    = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS - 1);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    chacha_state_t       r_work;
    chacha_state_t       r_orig;
    chacha_state_t       r_out;
    chacha_state_t       w_round_out;
    logic [4*ROW_W-1:0]  w_sum;
    logic [WORD_W-1:0]   w_sum_w [ST_WORDS];
    logic                w_op_type;
    logic                w_in_fire;
    logic                w_in_ready_nxt;
    logic                w_out_valid_nxt;
    logic                w_busy_nxt;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_busy;

    assign w_in_fire = (r_state == ST_IDLE) && in_valid;
    assign w_op_type = r_cnt[0];

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (in_valid)            w_state_nxt = ST_RUN;
            ST_RUN:  if (r_cnt == LAST_RND)   w_state_nxt = ST_ADD;
            ST_ADD:                           w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready)           w_state_nxt = ST_IDLE;
            default:                          w_state_nxt = ST_IDLE;
        endcase
    end

    // Handshake/status decodes of the upcoming state, registered below
    always_comb begin
        w_in_ready_nxt  = 1'b0;
        w_out_valid_nxt = 1'b0;
        w_busy_nxt      = 1'b0;
        unique case (w_state_nxt)
            ST_IDLE: w_in_ready_nxt  = 1'b1;
            ST_RUN:  w_busy_nxt      = 1'b1;
            ST_ADD:  w_busy_nxt      = 1'b1;
            ST_DONE: w_out_valid_nxt = 1'b1;
            default: w_in_ready_nxt  = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    round u_round (
        .i_state   (r_work),
        .i_op_type (w_op_type),
        .o_state   (w_round_out)
    );

    // Feed-forward: 16 independent mod-2^32 word adders
    for (genvar g = 0; g < int'(ST_WORDS); g++) begin : g_ff
        assign w_sum_w[g] = r_work[WORD_W*g +: WORD_W] + r_orig[WORD_W*g +: WORD_W];
    end

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < int'(ST_WORDS); k++) begin
            w_sum[WORD_W*k +: WORD_W] = w_sum_w[k];
        end
    end

    // Datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt  <= '0;
            r_work <= '0;
            r_orig <= '0;
            r_out  <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_in_fire) begin
                        r_work <= '{a: in_a, b: in_b, c: in_c, d: in_d};
                        r_orig <= '{a: in_a, b: in_b, c: in_c, d: in_d};
                        r_cnt  <= '0;
                    end
                end
                ST_RUN: begin
                    r_work <= w_round_out;
                    r_cnt  <= r_cnt + 1'b1;
                end
                ST_ADD:  r_out <= w_sum;
                default: ;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign out_a     = r_out.a;
    assign out_b     = r_out.b;
    assign out_c     = r_out.c;
    assign out_d     = r_out.d;

endmodule

// File: tb/tb_chacha_block_ctrl.sv
// Directed bench for chacha_block_ctrl: RFC 8439 block vector at 20 rounds,
// a 2-round zero-state instance, backpressure, mid-run reset and back-to-back.
module tb_chacha_block_ctrl;
    import chacha_pkg::*;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] in_a, in_b, in_c, in_d, out_a, out_b, out_c, out_d;
    logic         z_in_valid, z_in_ready, z_out_valid, z_out_ready, z_busy;
    logic [127:0] z_in, z_out_a, z_out_b, z_out_c, z_out_d;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] RFC_A = {SIGMA3, SIGMA2, SIGMA1, SIGMA0};
    localparam logic [127:0] RFC_B = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    localparam logic [127:0] RFC_C = 128'h1f1e1d1c_1b1a1918_17161514_13121110;
    localparam logic [127:0] EXP_A = 128'hc47120a3_1fdd0f50_15593bd1_e4e7f110;
    localparam logic [127:0] EXP_B = 128'h4e6cd4c3_9aaa2204_0368c033_c7f4d1c7;
    localparam logic [127:0] EXP_C = 128'ha2028bd9_05d7c214_09aa9f07_466482d2;
    localparam logic [127:0] EXP_D = 128'h4e3c50a2_e883d0cb_b94e16de_d19c12b5;

    always #5 clock = ~clock;

    chacha_block_ctrl #(.ROUNDS(20)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d),
        .busy(busy)
    );

    chacha_block_ctrl #(.ROUNDS(2)) dut2 (
        .clock(clock), .reset(reset),
        .in_valid(z_in_valid), .in_ready(z_in_ready),
        .in_a(z_in), .in_b(z_in), .in_c(z_in), .in_d(z_in),
        .out_valid(z_out_valid), .out_ready(z_out_ready),
        .out_a(z_out_a), .out_b(z_out_b), .out_c(z_out_c), .out_d(z_out_d),
        .busy(z_busy)
    );

    function automatic logic [127:0] rfc_d(input logic [31:0] ctr);
        return {32'h00000000, 32'h4a000000, 32'h09000000, ctr};
    endfunction

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Accept one block in IDLE, then count cycles until out_valid (bounded).
    task automatic run_block(input logic [127:0] d_row, output int lat);
        in_a = RFC_A; in_b = RFC_B; in_c = RFC_C; in_d = d_row;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 60) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int           lat, cyc, t0, t1, nres;
        logic [511:0] res0, res1;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_c = '0; in_d = '0;
        z_in_valid = 1'b0; z_out_ready = 1'b1; z_in = '0;
        tick(); tick();
        chk("rst_in_ready", 512'(in_ready), 512'(1));
        chk("rst_out_valid", 512'(out_valid), 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_out_a", 512'(out_a), 512'(0));
        chk("rst_z_in_ready", 512'(z_in_ready), 512'(1));
        reset = 1'b0;
        tick();

        // Two-round instance on an all-zero state
        z_in_valid = 1'b1;
        tick();
        z_in_valid = 1'b0;
        chk("zero_op0", 512'(dut2.w_op_type), 512'(OP_COLUMN));
        chk("zero_busy", 512'(z_busy), 512'(1));
        tick();
        chk("zero_op1", 512'(dut2.w_op_type), 512'(OP_DIAG));
        chk("zero_valid_e1", 512'(z_out_valid), 512'(0));
        tick();
        chk("zero_valid_e2", 512'(z_out_valid), 512'(0));
        tick();
        chk("zero_valid_e3", 512'(z_out_valid), 512'(1));
        chk("zero_out", {z_out_a, z_out_b, z_out_c, z_out_d}, 512'(0));
        tick();
        chk("zero_in_ready", 512'(z_in_ready), 512'(1));

        // RFC 8439 block function vector
        run_block(rfc_d(32'd1), lat);
        chk("rfc_latency", 512'(lat), 512'(21));
        chk("rfc_out_a", 512'(out_a), 512'(EXP_A));
        chk("rfc_out_b", 512'(out_b), 512'(EXP_B));
        chk("rfc_out_c", 512'(out_c), 512'(EXP_C));
        chk("rfc_out_d", 512'(out_d), 512'(EXP_D));
        chk("rfc_busy", 512'(busy), 512'(0));
        chk("rfc_in_ready", 512'(in_ready), 512'(0));

        // Backpressure with an offered block that must be ignored
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_a = ~RFC_A; in_d = rfc_d(32'd7);
            tick();
            chk("bp_valid", 512'(out_valid), 512'(1));
            chk("bp_in_ready", 512'(in_ready), 512'(0));
            chk("bp_out", {out_a, out_b, out_c, out_d}, {EXP_A, EXP_B, EXP_C, EXP_D});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hs_in_ready", 512'(in_ready), 512'(1));
        chk("hs_out_valid", 512'(out_valid), 512'(0));
        chk("hs_out_hold", {out_a, out_d}, {EXP_A, EXP_D});
        tick();
        chk("hs_not_captured", 512'(busy), 512'(0));
        chk("hs_idle_ready", 512'(in_ready), 512'(1));

        // Reset on the seventh RUN cycle
        in_a = RFC_A; in_b = RFC_B; in_c = RFC_C; in_d = rfc_d(32'd1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        chk("mid_busy", 512'(busy), 512'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst_in_ready", 512'(in_ready), 512'(1));
        chk("mrst_out_valid", 512'(out_valid), 512'(0));
        chk("mrst_busy", 512'(busy), 512'(0));
        chk("mrst_out", {out_a, out_b, out_c, out_d}, 512'(0));

        run_block(rfc_d(32'd1), lat);
        chk("rfc2_latency", 512'(lat), 512'(21));
        chk("rfc2_out", {out_a, out_b, out_c, out_d}, {EXP_A, EXP_B, EXP_C, EXP_D});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Back-to-back blocks, counter 1 then counter 2
        in_a = RFC_A; in_b = RFC_B; in_c = RFC_C; in_d = rfc_d(32'd1);
        in_valid = 1'b1; out_ready = 1'b1;
        cyc = 0; t0 = -1; t1 = -1; nres = 0; res0 = '0; res1 = '0;
        while (nres < 2 && cyc < 120) begin
            if (in_valid && in_ready) begin
                if (t0 < 0) t0 = cyc;
                else        t1 = cyc;
            end
            if (out_valid && out_ready) begin
                if (nres == 0) res0 = {out_a, out_b, out_c, out_d};
                else           res1 = {out_a, out_b, out_c, out_d};
                nres++;
            end
            tick();
            cyc++;
            if (t0 >= 0 && t1 < 0) in_d = rfc_d(32'd2);
            if (t1 >= 0) in_valid = 1'b0;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b_results", 512'(nres), 512'(2));
        chk("b2b_spacing", 512'(t1 - t0), 512'(23));
        chk("b2b_first", res0, {EXP_A, EXP_B, EXP_C, EXP_D});
        chk("b2b_second_differs", 512'(res1 !== res0), 512'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
